// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the core PC, drives program memory and
// hands a registered instruction stream to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      pc_o,
    input  logic [31:0]      inst_i,
    output logic [31:0]      ir_o,
    output logic [31:0]      ir_pc_o,
    output logic             ir_valid_o,
    input  logic             ir_ready_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_target_i,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // 33 bits so MEM_WORDS*4 cannot overflow for any 32-bit PC comparison
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      ir_pc_q, ir_pc_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             load;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a} >= MEM_BYTES);
    endfunction

    assign accept = vld_q & ir_ready_i;
    assign load   = (state_q == S_RUN) & (~vld_q | ir_ready_i);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        vld_d   = vld_q;
        cnt_d   = (accept && (cnt_q != '1)) ? cnt_q + CNT_ONE : cnt_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                // Redirect wins over both a fresh load and a stall, flushing the IR
                if (br_taken_i) begin
                    pc_d  = br_target_i;
                    vld_d = 1'b0;
                    if (addr_bad(br_target_i)) state_d = S_ERR;
                end else if (load) begin
                    if (addr_bad(pc_q)) begin
                        state_d = S_ERR;
                        vld_d   = 1'b0;
                    end else begin
                        ir_d    = inst_i;
                        ir_pc_d = pc_q;
                        vld_d   = 1'b1;
                        if (inst_i == HALT_INST) state_d = S_HALT;
                        else                     pc_d    = pc_q + 32'd4;
                    end
                end
            end
            S_HALT: if (accept) vld_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ir_pc_q <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o        = pc_q;
    assign ir_o        = ir_q;
    assign ir_pc_o     = ir_pc_q;
    assign ir_valid_o  = vld_q;
    assign halted_o    = (state_q == S_HALT);
    assign err_o       = (state_q == S_ERR);
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized ready/redirect
// traffic, checked by a scoreboard fed from a transaction-level reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_o, inst_i, ir_o, ir_pc_o, br_target_i;
    logic          ir_valid_o, ir_ready_i, br_taken_i, halted_o, err_o;
    logic [CW-1:0] fetch_cnt_o;

    logic [31:0] mem [64];
    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;

    // reference model state: what the fetch unit should be showing right now
    logic [31:0] m_pc, m_ir, m_irpc;
    logic        m_v, m_boot, m_halt, m_err;
    int          m_cnt;

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(64), .HALT_INST(HALT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pc_o(pc_o), .inst_i(inst_i), .ir_o(ir_o),
        .ir_pc_o(ir_pc_o), .ir_valid_o(ir_valid_o), .ir_ready_i(ir_ready_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i), .halted_o(halted_o),
        .err_o(err_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    assign inst_i = (pc_o[1:0] == 2'b00 && pc_o < 32'd256) ? mem[pc_o[7:2]] : 32'hDEAD_BEEF;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 0; m_irpc = 0; m_v = 0;
        m_boot = 1; m_halt = 0; m_err = 0; m_cnt = 0;
    endtask

    // What one rising edge does to the architectural fetch stream
    task automatic model_edge(input logic rdy, input logic br, input logic [31:0] tgt);
        logic taken;
        if (!rst) begin
            model_reset();
        end else begin
            taken = m_v && rdy;
            if (taken && m_cnt < CMAX) m_cnt++;
            if (m_boot) begin
                m_boot = 0;
            end else if (m_halt) begin
                if (taken) m_v = 0;
            end else if (!m_err) begin
                if (br) begin
                    m_pc = tgt;
                    m_v  = 0;
                    m_err = bad_addr(tgt);
                end else if (!m_v || rdy) begin
                    if (bad_addr(m_pc)) begin
                        m_err = 1; m_v = 0;
                    end else begin
                        m_irpc = m_pc;
                        m_ir   = mem[m_pc / 4];
                        m_v    = 1;
                        if (m_ir == HALT) m_halt = 1;
                        else              m_pc = m_pc + 4;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
        exp_t e;
        ir_ready_i = rdy; br_taken_i = br; br_target_i = tgt;
        if (m_v && rdy) begin
            e.pc = m_irpc; e.ir = m_ir;
            sb.push_back(e);
        end
        @(posedge clk);
        model_edge(rdy, br, tgt);
        #1;
    endtask

    task automatic fill_mem(input int halt_idx);
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom();
            if (mem[i] == HALT) mem[i] = 32'h0;
        end
        if (halt_idx >= 0) mem[halt_idx] = HALT;
    endtask

    // Enter reset from the post-edge phase, hold it across one edge, release.
    task automatic do_reset(input int halt_idx);
        rst = 1'b0;
        #1;
        model_reset();
        sb.delete();
        fill_mem(halt_idx);
        step(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
    endtask

    // Monitor: every falling edge compare DUT against the model, pop on accept
    always @(negedge clk) begin
        exp_t e;
        chk("pc", pc_o, m_pc);
        chk("valid", 32'(ir_valid_o), 32'(m_v));
        chk("halted", 32'(halted_o), 32'(m_halt));
        chk("err", 32'(err_o), 32'(m_err));
        chk("cnt", 32'(fetch_cnt_o), 32'(m_cnt));
        if (m_v) begin
            chk("ir_pc", ir_pc_o, m_irpc);
            chk("ir", ir_o, m_ir);
        end
        if (ir_valid_o && ir_ready_i) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_pop: got accept of pc %h want no accept", ir_pc_o);
            end else begin
                e = sb.pop_front();
                chk("acc_pc", ir_pc_o, e.pc);
                chk("acc_ir", ir_o, e.ir);
            end
        end
    end

    initial begin
        ir_ready_i = 0; br_taken_i = 0; br_target_i = 0;
        rst = 1'b1;
        model_reset();
        fill_mem(-1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_ir", ir_o, 32'h0);
        chk("rst_irpc", ir_pc_o, 32'h0);
        chk("rst_valid", 32'(ir_valid_o), 0);
        chk("rst_halted", 32'(halted_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_cnt", 32'(fetch_cnt_o), 0);

        // 1) three words then HALT at 12
        do_reset(3);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
        chk("t1_halted", 32'(halted_o), 1);
        chk("t1_cnt", 32'(fetch_cnt_o), 4);
        chk("t1_pc", pc_o, 32'd12);
        chk("t1_valid", 32'(ir_valid_o), 0);

        // 2) stall with ir_pc=4, then 3) redirect while stalled on 8
        do_reset(-1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t2_pc", pc_o, 32'd8);
            chk("t2_irpc", ir_pc_o, 32'd4);
            chk("t2_ir", ir_o, mem[1]);
        end
        step(1'b1, 1'b0, 32'h0);
        chk("t2_next", ir_pc_o, 32'd8);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h20);
        chk("t3_flush", 32'(ir_valid_o), 0);
        chk("t3_cnt", 32'(fetch_cnt_o), 2);
        step(1'b1, 1'b0, 32'h0);
        chk("t3_tgt", ir_pc_o, 32'h20);
        chk("t3_valid", 32'(ir_valid_o), 1);

        // 4) misaligned target, then ignored redirects
        step(1'b1, 1'b1, 32'h22);
        chk("t4_err", 32'(err_o), 1);
        chk("t4_pc", pc_o, 32'h22);
        chk("t4_valid", 32'(ir_valid_o), 0);
        step(1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 32'h40);
        chk("t4_ign", pc_o, 32'h22);
        do_reset(-1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h100);
        chk("t4_err2", 32'(err_o), 1);
        chk("t4_pc2", pc_o, 32'h100);

        // 5) run off the end of memory; counter saturates
        do_reset(-1);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 32'h0);
        chk("t5_err", 32'(err_o), 1);
        chk("t5_pc", pc_o, 32'd256);
        chk("t5_cnt", 32'(fetch_cnt_o), CMAX);

        // 6) async reset during a stall
        do_reset(-1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("t6_pc", pc_o, 32'h0);
        chk("t6_ir", ir_o, 32'h0);
        chk("t6_irpc", ir_pc_o, 32'h0);
        chk("t6_valid", 32'(ir_valid_o), 0);
        chk("t6_cnt", 32'(fetch_cnt_o), 0);
        model_reset();
        sb.delete();
        step(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        chk("t6_boot", 32'(ir_valid_o), 0);
        step(1'b1, 1'b0, 32'h0);
        chk("t6_first", ir_pc_o, 32'h0);
        chk("t6_fvalid", 32'(ir_valid_o), 1);

        // 7) randomized traffic
        for (int r = 0; r < 6; r++) begin
            do_reset(($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 63)) : -1);
            for (int i = 0; i < 150; i++) begin
                logic [31:0] t;
                if ($urandom_range(0, 15) == 0) t = $urandom();
                else t = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, t);
            end
        end

        step(1'b0, 1'b0, 32'h0);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
